// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad divider: debounce FSM encoding and the
// key indices that stop and start the divider.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam int KEY_STOP = 0;

    // The start key is the highest-index key, so it depends on the keypad size.
    function automatic int key_start(input int num_keys);
        return num_keys - 1;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Key synchroniser, press/release debounce FSM and lowest-index priority encoder.
// Optional sticky multi-key flag is compiled in with KEYPAD_DIV_MULTI_ERR_EN.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS     = 10,
    parameter int CODE_W       = 4,
    parameter int DEBOUNCE_CYC = 4
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_KEYS-1:0] i_keys,
    output logic                o_accept,
    output logic [CODE_W-1:0]   o_accept_code,
    output logic [CODE_W-1:0]   o_code,
    output logic                o_code_valid,
    output logic                o_key_held,
    output logic                o_err_multi
);

    localparam logic [7:0] DEB_CNT = 8'(DEBOUNCE_CYC);

    logic [NUM_KEYS-1:0] r_sync1, r_sync2, r_vec, w_vec_nxt;
    logic [7:0]          r_cnt, w_cnt_nxt;
    kp_state_e           r_state, w_state_nxt;
    logic [CODE_W-1:0]   r_code, w_low;
    logic                r_code_valid, w_accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
        end else begin
            r_sync1      <= i_keys;
            r_sync2      <= r_sync1;
            r_state      <= w_state_nxt;
            r_vec        <= w_vec_nxt;
            r_cnt        <= w_cnt_nxt;
            r_code_valid <= w_accept;
            if (w_accept)
                r_code <= w_low;
        end
    end

    // Any change of the synced vector while debouncing restarts the count.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2 != '0) begin
                    w_state_nxt = ST_DEBOUNCE;
                    w_vec_nxt   = r_sync2;
                    w_cnt_nxt   = 8'd1;
                end
            end
            ST_DEBOUNCE: begin
                if (r_sync2 == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_sync2 != r_vec) begin
                    w_vec_nxt = r_sync2;
                    w_cnt_nxt = 8'd1;
                end else if (r_cnt >= DEB_CNT) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_PRESSED: begin
                if (r_sync2 == '0) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = 8'd1;
                end
            end
            ST_RELEASE: begin
                if (r_sync2 != '0) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= DEB_CNT) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_low = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (r_vec[i])
                w_low = CODE_W'(i);
    end

`ifdef KEYPAD_DIV_MULTI_ERR_EN
    logic r_err;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_err <= 1'b0;
        else if (w_accept && ($countones(r_vec) > 1))
            r_err <= 1'b1;
    end
    assign o_err_multi = r_err;
`else
    assign o_err_multi = 1'b0;
`endif

    assign o_accept      = w_accept;
    assign o_accept_code = w_low;
    assign o_code        = r_code;
    assign o_code_valid  = r_code_valid;
    assign o_key_held    = (r_state == ST_PRESSED) || (r_state == ST_RELEASE);

endmodule

// File: rtl/keypad_divider.sv
// Debounced keypad driving a free-running toggle divider (stop key / start key).
// Define KEYPAD_DIV_MULTI_ERR_EN to enable the sticky err_multi flag.
module keypad_divider
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS     = 10,
    parameter int CODE_W       = 4,
    parameter int DEBOUNCE_CYC = 4,
    parameter int DIV_STAGES   = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_KEYS-1:0]   keys,
    input  logic                  mode,
    output logic [CODE_W-1:0]     code,
    output logic                  code_valid,
    output logic                  key_held,
    output logic [DIV_STAGES-1:0] taps,
    output logic [DIV_STAGES-1:0] taps_n,
    output logic                  err_multi
);

    localparam logic [CODE_W-1:0] C_STOP  = CODE_W'(KEY_STOP);
    localparam logic [CODE_W-1:0] C_START = CODE_W'(key_start(NUM_KEYS));

    logic                  w_accept, w_stop, w_start;
    logic [CODE_W-1:0]     w_accept_code;
    logic [DIV_STAGES-1:0] r_cnt;
    logic                  r_run;

    keypad_debounce #(
        .NUM_KEYS    (NUM_KEYS),
        .CODE_W      (CODE_W),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
        .i_clk        (clk),
        .i_rst        (reset),
        .i_keys       (keys),
        .o_accept     (w_accept),
        .o_accept_code(w_accept_code),
        .o_code       (code),
        .o_code_valid (code_valid),
        .o_key_held   (key_held),
        .o_err_multi  (err_multi)
    );

    // Acting on the accept strobe lines the divider update up with code_valid.
    assign w_stop  = w_accept && !mode && (w_accept_code == C_STOP);
    assign w_start = w_accept && !mode && (w_accept_code == C_START);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (w_stop) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else begin
            if (r_run && !mode)
                r_cnt <= r_cnt + DIV_STAGES'(1);
            if (w_start)
                r_run <= 1'b1;
        end
    end

    assign taps   = r_cnt;
    assign taps_n = ~r_cnt;

endmodule

// File: tb/tb_keypad_divider.sv
// Randomized self-checking bench for keypad_divider against a timeline/arithmetic model.
module tb_keypad_divider;
    localparam int NK = 10, CW = 4, DB = 4, DS = 4;
    localparam int LAT = 2 + DB + 1;

    logic          clk = 1'b0;
    logic          reset, mode;
    logic [NK-1:0] keys;
    logic [CW-1:0] code;
    logic          code_valid, key_held, err_multi;
    logic [DS-1:0] taps, taps_n;

    int checks = 0, passes = 0;
    int m_cnt = 0, m_code = 0;
    bit m_run = 0, m_err = 0;

    always #5 clk = ~clk;

    keypad_divider #(.NUM_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYC(DB), .DIV_STAGES(DS)) dut (
        .clk(clk), .reset(reset), .keys(keys), .mode(mode), .code(code),
        .code_valid(code_valid), .key_held(key_held), .taps(taps), .taps_n(taps_n),
        .err_multi(err_multi)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int lowest(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Divider behaviour for one clock edge given whether a key was accepted on it.
    task automatic model_step(input bit acc, input int k);
        if (acc && !mode && k == 0) begin
            m_cnt = 0;
            m_run = 0;
        end else begin
            if (m_run && !mode) m_cnt = (m_cnt + 1) % (1 << DS);
            if (acc && !mode && k == NK - 1) m_run = 1;
        end
        if (acc) m_code = k;
    endtask

    function automatic bit taps_ok();
        logic [DS-1:0] e;
        e = DS'(m_cnt);
        return (taps === e) && (taps_n === ~e);
    endfunction

    task automatic model_reset;
        m_cnt = 0; m_run = 0; m_err = 0; m_code = 0;
    endtask

    task automatic idle_ticks(input int n, input string nm);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            tick;
            model_step(1'b0, 0);
            if (!taps_ok() || code_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL %s idle: %0d bad cycles, required 0 (taps=%0d exp=%0d)", nm, bad, taps, m_cnt);
        else passes++;
    endtask

    // Clean press held for `hold` cycles, then released and debounced back to idle.
    task automatic do_press(input logic [NK-1:0] vec, input int hold, input string nm);
        int pulses = 0, ppos = -1, held_bad = 0, tap_bad = 0;
        int k = lowest(vec);
        keys = vec;
        for (int i = 1; i <= hold + LAT + 1; i++) begin
            tick;
            model_step(i == LAT, k);
            if (code_valid === 1'b1) begin pulses++; ppos = i; end
            if (key_held !== (i >= LAT && i < hold + LAT)) held_bad++;
            if (!taps_ok()) tap_bad++;
            if (i == hold) keys = '0;
        end
`ifdef KEYPAD_DIV_MULTI_ERR_EN
        if ($countones(vec) > 1) m_err = 1;
`endif
        checks++;
        if (pulses != 1 || ppos != LAT) $display("FAIL %s pulse: count=%0d at=%0d, required 1 at %0d", nm, pulses, ppos, LAT);
        else passes++;
        checks++;
        if (code !== CW'(m_code)) $display("FAIL %s code: got %0d, required %0d", nm, code, m_code);
        else passes++;
        checks++;
        if (held_bad != 0) $display("FAIL %s key_held: %0d bad cycles, required 0", nm, held_bad);
        else passes++;
        checks++;
        if (tap_bad != 0) $display("FAIL %s taps: %0d bad cycles, required 0 (taps=%0d exp=%0d)", nm, tap_bad, taps, m_cnt);
        else passes++;
        checks++;
        if (err_multi !== m_err) $display("FAIL %s err_multi: got %b, required %b", nm, err_multi, m_err);
        else passes++;
    endtask

    task automatic check_reset_vals(input string nm);
        checks++;
        if ({code, code_valid, key_held, taps, taps_n, err_multi} !== {CW'(0), 1'b0, 1'b0, DS'(0), {DS{1'b1}}, 1'b0})
            $display("FAIL %s: code=%0d cv=%b held=%b taps=%h taps_n=%h err=%b, required 0 0 0 0 %h 0",
                     nm, code, code_valid, key_held, taps, taps_n, err_multi, {DS{1'b1}});
        else passes++;
    endtask

    task automatic test_reset;
        reset = 1'b1; keys = '0; mode = 1'b0;
        tick; tick;
        check_reset_vals("reset");
        reset = 1'b0;
        model_reset();
        idle_ticks(3, "post_reset");
    endtask

    task automatic test_key3;
        do_press(NK'(1) << 3, 10, "key3");
    endtask

    task automatic test_bounce;
        int pulses = 0, ppos = -1;
        for (int j = 1; j <= 36; j++) begin
            int ph = j - 1;
            if (ph < 12)      keys = (((ph / 2) % 2) == 0) ? (NK'(1) << 5) : '0;
            else if (ph < 24) keys = NK'(1) << 5;
            else              keys = '0;
            tick;
            model_step(j == 12 + LAT, 5);
            if (code_valid === 1'b1) begin pulses++; ppos = j; end
        end
        checks++;
        if (pulses != 1 || ppos != 12 + LAT) $display("FAIL bounce pulse: count=%0d at=%0d, required 1 at %0d", pulses, ppos, 12 + LAT);
        else passes++;
        checks++;
        if (code !== CW'(5)) $display("FAIL bounce code: got %0d, required 5", code);
        else passes++;
    endtask

    task automatic test_divider;
        int rise1 = -1, rise2 = -1, bad = 0;
        logic prev;
        do_press(NK'(1) << (NK - 1), 10, "start");
        prev = taps[DS-1];
        for (int i = 0; i < 48; i++) begin
            tick;
            model_step(1'b0, 0);
            if (!taps_ok()) bad++;
            if (taps[DS-1] && !prev) begin
                if (rise1 < 0) rise1 = i; else if (rise2 < 0) rise2 = i;
            end
            prev = taps[DS-1];
        end
        checks++;
        if (bad != 0) $display("FAIL run taps: %0d bad cycles, required 0", bad);
        else passes++;
        checks++;
        if (rise2 - rise1 != (1 << DS) || rise1 < 0) $display("FAIL tap_msb period: got %0d, required %0d", rise2 - rise1, 1 << DS);
        else passes++;
        do_press(NK'(1), 10, "stop");
        checks++;
        if (taps !== '0) $display("FAIL stop taps: got %0d, required 0", taps);
        else passes++;
        idle_ticks(20, "stopped");
    endtask

    task automatic test_mode_freeze;
        do_press(NK'(1) << (NK - 1), 10, "start2");
        for (int i = 0; i < 40 && m_cnt != 6; i++) begin
            tick;
            model_step(1'b0, 0);
        end
        checks++;
        if (taps !== DS'(6)) $display("FAIL reach6 taps: got %0d, required 6", taps);
        else passes++;
        mode = 1'b1;
        do_press(NK'(1), 10, "frozen_key0");
        checks++;
        if (taps !== DS'(6)) $display("FAIL frozen taps: got %0d, required 6", taps);
        else passes++;
        mode = 1'b0;
        idle_ticks(5, "resume");
        do_press(NK'(1), 10, "stop2");
    endtask

    task automatic test_multi;
        do_press((NK'(1) << 2) | (NK'(1) << 7), 10, "multi");
        checks++;
`ifdef KEYPAD_DIV_MULTI_ERR_EN
        if (err_multi !== 1'b1) $display("FAIL multi flag: got %b, required 1", err_multi);
        else passes++;
`else
        if (err_multi !== 1'b0) $display("FAIL multi flag: got %b, required 0", err_multi);
        else passes++;
`endif
    endtask

    task automatic test_random;
        for (int n = 0; n < 10; n++) begin
            logic [NK-1:0] v;
            v = NK'($urandom_range(1, (1 << NK) - 1));
            mode = 1'($urandom_range(0, 1));
            do_press(v, $urandom_range(8, 16), $sformatf("rand%0d", n));
            idle_ticks($urandom_range(1, 4), $sformatf("gap%0d", n));
        end
        mode = 1'b0;
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        mode = 1'b0;
        do_press(NK'(1) << (NK - 1), 10, "start3");
        keys = NK'(1) << 4;
        for (int i = 0; i < 4; i++) begin tick; model_step(1'b0, 0); end
        reset = 1'b1;
        #1;
        check_reset_vals("reset_debounce");
        model_reset();
        keys = '0;
        tick; tick;
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (code_valid !== 1'b0 || key_held !== 1'b0 || taps !== '0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL after_reset_debounce: %0d bad cycles, required 0", bad);
        else passes++;
        keys = NK'(1) << 4;
        for (int i = 0; i < LAT + 2; i++) tick;
        reset = 1'b1;
        #1;
        check_reset_vals("reset_pressed");
        keys = '0;
        tick; tick;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (code_valid !== 1'b0 || key_held !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL after_reset_pressed: %0d bad cycles, required 0", bad);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_key3();
        test_bounce();
        test_divider();
        test_mode_freeze();
        test_multi();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/keypad_divider.md
KEYPAD_DIVIDER -- requirements
Module: keypad_divider

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 10, number of keypad key inputs (2..16).
REQ-002 SHALL have parameter CODE_W, default 4, key-code width; CODE_W >= clog2(NUM_KEYS).
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 4, consecutive stable cycles required to accept a press or release (1..255).
REQ-004 SHALL have parameter DIV_STAGES, default 4, number of toggle-divider stages.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port keys  input  NUM_KEYS  raw asynchronous key levels, 1 = pressed.
REQ-008 SHALL have port mode  input  1  0 = divider follows key commands, 1 = divider frozen (codes still latched).
REQ-009 SHALL have port code  output  CODE_W  index of last accepted key.
REQ-010 SHALL have port code_valid  output  1  one-cycle pulse on each accepted press.
REQ-011 SHALL have port key_held  output  1  high while an accepted press is held.
REQ-012 SHALL have port taps  output  DIV_STAGES  divider stage outputs; taps[i] toggles every 2^i enabled cycles.
REQ-013 SHALL have port taps_n  output  DIV_STAGES  bitwise complement of taps.
REQ-014 SHALL have port err_multi  output  1  sticky flag: more than one key seen at acceptance.

Function
REQ-015 SHALL pass keys through a two-flop synchroniser; total press-to-code_valid latency = 2 + DEBOUNCE_CYC + 1 cycles.
REQ-016 SHALL run FSM IDLE -> DEBOUNCE (any synced key high) -> PRESSED (same key vector stable DEBOUNCE_CYC cycles) -> RELEASE (all keys low) -> IDLE (all low stable DEBOUNCE_CYC cycles).
REQ-017 SHALL restart the debounce count whenever the synced key vector changes in DEBOUNCE or RELEASE; DEBOUNCE returns to IDLE if all keys drop.
REQ-018 SHALL, on DEBOUNCE->PRESSED, latch code = lowest-index pressed key and pulse code_valid for exactly one cycle.
REQ-019 SHALL ignore additional presses while in PRESSED; a RELEASE that sees keys reappear returns to PRESSED without a new code_valid.
REQ-020 SHALL drive key_held high in PRESSED and RELEASE, low otherwise.
REQ-021 SHALL keep a DIV_STAGES-bit counter; taps = counter; counter increments by 1 each cycle when run=1 and mode=0, wrapping all-ones -> 0.
REQ-022 SHALL, on accepted key 0 with mode=0, clear counter and set run=0 in the same cycle as code_valid.
REQ-023 SHALL, on accepted key NUM_KEYS-1 with mode=0, set run=1; counting starts the following cycle.
REQ-024 SHALL leave run and counter unchanged for other keys or when mode=1; mode=1 freezes counter value.

Reset
REQ-025 SHALL on reset asynchronously force FSM=IDLE, synchroniser and debounce count=0, code=0, code_valid=0, key_held=0, run=0, taps=0, taps_n=all ones, err_multi=0.
REQ-026 SHALL on reset mid-debounce or mid-press discard the pending key with no code_valid on release of reset.

Configuration
REQ-027 SHALL compile multi-key detection only when KEYPAD_DIV_MULTI_ERR_EN is defined: err_multi sets when >1 key is high at acceptance and clears only on reset.
REQ-028 SHALL, without KEYPAD_DIV_MULTI_ERR_EN, tie err_multi to 0; priority selection is unchanged.

Structure
REQ-029 SHALL place FSM state encoding (IDLE, DEBOUNCE, PRESSED, RELEASE) and the stop/start key-index constants in shared package keypad_pkg.
REQ-030 SHALL implement debounce + priority encode as sub-module keypad_debounce; divider counter stays in the top level.

Verification
REQ-031 SHALL test: reset, press key 3 held 10 cycles, DEBOUNCE_CYC=4 -> code=3, single code_valid 7 cycles after press, key_held high until release debounced.
REQ-032 SHALL test: key 5 bouncing 0/1 every 2 cycles for 12 cycles then stable -> exactly one code_valid, code=5.
REQ-033 SHALL test: press key 9 (mode=0) -> taps counts 0,1,2..15,0; taps[3] period 16 cycles; press key 0 -> taps=0, counting stops.
REQ-034 SHALL test: keys 2 and 7 together -> code=2; err_multi=1 with KEYPAD_DIV_MULTI_ERR_EN, 0 without.
REQ-035 SHALL test: counter running at 6, mode=1, press key 0 -> code=0, code_valid pulses, taps stays 6.
REQ-036 SHALL test: assert reset during DEBOUNCE of key 4 -> all outputs at reset values, no code_valid after reset deasserts with keys low.
